// File: rtl/ifetch.sv
// Instruction-fetch stage: direct-mapped, one-word-per-line I-cache feeding the decoder,
// with a single outstanding word request to the memory arbiter on a miss.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned LINES    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        need_inst,
  input  logic        clear_inst,
  input  logic [31:0] if_addr,
  output logic [31:0] PC,
  output logic [31:0] inst_out,
  output logic        instcache_ready_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
);

  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = 32 - IW - 2;

  typedef enum logic [0:0] {StIdle, StMiss} state_e;

  state_e            r_state, w_state_d;
  logic [31:0]       r_fpc, w_fpc_d;
  logic [31:0]       r_pc, w_pc_d;
  logic [31:0]       r_inst, w_inst_d;
  logic              r_ready, w_ready_d;
  logic              r_mem_req, w_mem_req_d;
  logic [31:0]       r_mem_addr, w_mem_addr_d;
  logic              r_drop, w_drop_d;
  logic [LINES-1:0]  r_valid;
  logic [TW-1:0]     r_tag  [LINES];
  logic [31:0]       r_data [LINES];

  logic [IW-1:0]     w_idx;
  logic [IW-1:0]     w_fidx;
  logic              w_hit;
  logic              w_slot_free;
  logic              w_fill;
  logic [31:0]       w_target;

  assign w_idx       = r_fpc[IW+1:2];
  assign w_fidx      = r_mem_addr[IW+1:2];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == r_fpc[31:IW+2]);
  assign w_slot_free = !r_ready || need_inst;
  assign w_target    = {if_addr[31:2], 2'b00};

  always_comb begin
    w_state_d    = r_state;
    w_fpc_d      = r_fpc;
    w_pc_d       = r_pc;
    w_inst_d     = r_inst;
    w_ready_d    = r_ready;
    w_mem_req_d  = r_mem_req;
    w_mem_addr_d = r_mem_addr;
    w_drop_d     = r_drop;
    w_fill       = 1'b0;
    if (rdy) begin
      unique case (r_state)
        StIdle: begin
          if (clear_inst) begin
            w_ready_d = 1'b0;
            w_fpc_d   = w_target;
          end else if (w_slot_free) begin
            if (w_hit) begin
              w_pc_d    = r_fpc;
              w_inst_d  = r_data[w_idx];
              w_ready_d = 1'b1;
              w_fpc_d   = r_fpc + 32'd4;
            end else begin
              w_mem_req_d  = 1'b1;
              w_mem_addr_d = r_fpc;
              w_state_d    = StMiss;
              w_ready_d    = 1'b0;
            end
          end
        end
        StMiss: begin
          if (mem_ready) begin
            // The line is always filled, even when the word itself is discarded.
            w_fill      = 1'b1;
            w_mem_req_d = 1'b0;
            w_state_d   = StIdle;
            w_drop_d    = 1'b0;
            if (clear_inst) begin
              w_ready_d = 1'b0;
              w_fpc_d   = w_target;
            end else if (!r_drop) begin
              w_pc_d    = r_mem_addr;
              w_inst_d  = mem_data;
              w_ready_d = 1'b1;
              w_fpc_d   = r_mem_addr + 32'd4;
            end
          end else if (clear_inst) begin
            // Request is in flight and cannot be cancelled; mark its data stale.
            w_ready_d = 1'b0;
            w_fpc_d   = w_target;
            w_drop_d  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_fpc      <= RESET_PC;
      r_pc       <= 32'h0;
      r_inst     <= 32'h0;
      r_ready    <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 32'h0;
      r_drop     <= 1'b0;
      r_valid    <= '0;
    end else begin
      r_state    <= w_state_d;
      r_fpc      <= w_fpc_d;
      r_pc       <= w_pc_d;
      r_inst     <= w_inst_d;
      r_ready    <= w_ready_d;
      r_mem_req  <= w_mem_req_d;
      r_mem_addr <= w_mem_addr_d;
      r_drop     <= w_drop_d;
      if (w_fill) r_valid[w_fidx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_fidx]  <= r_mem_addr[31:IW+2];
      r_data[w_fidx] <= mem_data;
    end
  end

  assign PC                  = r_pc;
  assign inst_out            = r_inst;
  assign instcache_ready_out = r_ready;
  assign mem_req             = r_mem_req;
  assign mem_addr            = r_mem_addr;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: cold miss, warm hits, back-pressure, redirect during miss,
// index aliasing and rdy stall, each step checked against hand-computed values.
module tb_ifetch;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        need_inst;
  logic        clear_inst;
  logic [31:0] if_addr;
  logic [31:0] PC;
  logic [31:0] inst_out;
  logic        instcache_ready_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;

  int n_cmp = 0;
  int n_err = 0;

  ifetch #(
    .RESET_PC(32'h0),
    .LINES   (16)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .need_inst          (need_inst),
    .clear_inst         (clear_inst),
    .if_addr            (if_addr),
    .PC                 (PC),
    .inst_out           (inst_out),
    .instcache_ready_out(instcache_ready_out),
    .mem_req            (mem_req),
    .mem_addr           (mem_addr),
    .mem_ready          (mem_ready),
    .mem_data           (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic serve(input logic [31:0] d);
    mem_data  = d;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    rdy        = 1'b1;
    need_inst  = 1'b0;
    clear_inst = 1'b0;
    if_addr    = 32'h0;
    mem_ready  = 1'b0;
    mem_data   = 32'h0;
    #2;
    chk("rst_pc", PC, 32'h0);
    chk("rst_inst", inst_out, 32'h0);
    chk1("rst_ready", instcache_ready_out, 1'b0);
    chk1("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    step();
    step();
    rst = 1'b1;

    // Cold start
    step();
    chk1("cold_req", mem_req, 1'b1);
    chk("cold_addr", mem_addr, 32'h0);
    chk1("cold_ready0", instcache_ready_out, 1'b0);
    step();
    step();
    chk1("cold_req_hold", mem_req, 1'b1);
    serve(32'h0000_0013);
    chk1("cold_ready", instcache_ready_out, 1'b1);
    chk("cold_pc", PC, 32'h0);
    chk("cold_inst", inst_out, 32'h0000_0013);
    chk1("cold_req_drop", mem_req, 1'b0);
    need_inst = 1'b1;
    step();
    need_inst = 1'b0;
    chk1("next_req", mem_req, 1'b1);
    chk("next_addr", mem_addr, 32'h4);
    chk1("next_ready0", instcache_ready_out, 1'b0);
    serve(32'hA000_0004);
    chk("fill4_pc", PC, 32'h4);
    chk("fill4_inst", inst_out, 32'hA000_0004);

    // Fill lines 2 and 3
    need_inst = 1'b1;
    step();
    need_inst = 1'b0;
    chk("fill8_addr", mem_addr, 32'h8);
    serve(32'hA000_0008);
    chk("fill8_pc", PC, 32'h8);
    need_inst = 1'b1;
    step();
    need_inst = 1'b0;
    chk("fill12_addr", mem_addr, 32'hC);
    serve(32'hA000_000C);
    chk("fill12_pc", PC, 32'hC);

    // Warm loop: redirect to 0 beats the simultaneous consume
    need_inst  = 1'b1;
    clear_inst = 1'b1;
    if_addr    = 32'h0;
    step();
    clear_inst = 1'b0;
    chk1("redir_ready0", instcache_ready_out, 1'b0);
    step();
    chk("warm_pc0", PC, 32'h0);
    chk("warm_inst0", inst_out, 32'h0000_0013);
    chk1("warm_req0", mem_req, 1'b0);
    step();
    chk("warm_pc4", PC, 32'h4);
    chk("warm_inst4", inst_out, 32'hA000_0004);
    step();
    chk("warm_pc8", PC, 32'h8);
    chk1("warm_req8", mem_req, 1'b0);
    need_inst = 1'b0;

    // Back-pressure
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_pc", PC, 32'h8);
      chk("bp_inst", inst_out, 32'hA000_0008);
      chk1("bp_ready", instcache_ready_out, 1'b1);
      chk1("bp_req", mem_req, 1'b0);
    end
    need_inst = 1'b1;
    step();
    need_inst = 1'b0;
    chk("bp_rel_pc", PC, 32'hC);
    chk("bp_rel_inst", inst_out, 32'hA000_000C);

    // Redirect during miss: 0x40 aliases line 0
    clear_inst = 1'b1;
    if_addr    = 32'h40;
    step();
    clear_inst = 1'b0;
    chk1("r40_ready0", instcache_ready_out, 1'b0);
    step();
    chk1("alias40_req", mem_req, 1'b1);
    chk("alias40_addr", mem_addr, 32'h40);
    clear_inst = 1'b1;
    if_addr    = 32'h103;
    step();
    clear_inst = 1'b0;
    chk1("drop_ready0", instcache_ready_out, 1'b0);
    chk1("drop_req", mem_req, 1'b1);
    chk("drop_addr", mem_addr, 32'h40);
    step();
    chk("drop_addr_stable", mem_addr, 32'h40);
    serve(32'hBEEF_0040);
    chk1("drop_no_out", instcache_ready_out, 1'b0);
    chk1("drop_req_drop", mem_req, 1'b0);
    step();
    chk1("m100_req", mem_req, 1'b1);
    chk("m100_addr", mem_addr, 32'h100);
    chk1("m100_ready0", instcache_ready_out, 1'b0);
    serve(32'hC0DE_0100);
    chk1("m100_ready", instcache_ready_out, 1'b1);
    chk("m100_pc", PC, 32'h100);
    chk("m100_inst", inst_out, 32'hC0DE_0100);

    // Refetch of 0x0 misses again after aliasing
    clear_inst = 1'b1;
    if_addr    = 32'h0;
    step();
    clear_inst = 1'b0;
    step();
    chk1("refetch0_req", mem_req, 1'b1);
    chk("refetch0_addr", mem_addr, 32'h0);

    // rdy low mid-miss with mem_ready held
    rdy       = 1'b0;
    mem_ready = 1'b1;
    mem_data  = 32'h0000_0013;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("stall_ready", instcache_ready_out, 1'b0);
      chk1("stall_req", mem_req, 1'b1);
      chk("stall_addr", mem_addr, 32'h0);
      chk("stall_pc", PC, 32'h100);
    end
    rdy = 1'b1;
    step();
    mem_ready = 1'b0;
    chk1("stall_done_ready", instcache_ready_out, 1'b1);
    chk("stall_done_pc", PC, 32'h0);
    chk("stall_done_inst", inst_out, 32'h0000_0013);
    chk1("stall_done_req", mem_req, 1'b0);

    // Line 1 still holds 0x4: hit
    need_inst = 1'b1;
    step();
    need_inst = 1'b0;
    chk("post_hit_pc", PC, 32'h4);
    chk("post_hit_inst", inst_out, 32'hA000_0004);
    chk1("post_hit_req", mem_req, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction-fetch stage with a direct-mapped, one-word-per-line instruction cache. It sits directly upstream of the decoder and presents one instruction at a time with its PC. It advances when the decoder signals `need_inst` and redirects on `clear_inst`/`if_addr`. Misses are serviced through a single-outstanding word request to the memory arbiter.

## Interface
- `RESET_PC`, 32'h0, fetch address after reset
- `LINES`, 16, cache lines (power of two); index width `IW = log2(LINES)`
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `rdy`  in  1  global enable; low freezes all state, outputs hold
- `need_inst`  in  1  decoder accepts the presented instruction this cycle
- `clear_inst`  in  1  redirect request from decoder
- `if_addr`  in  32  redirect target
- `PC`  out  32  address of presented instruction
- `inst_out`  out  32  presented instruction word
- `instcache_ready_out`  out  1  `PC`/`inst_out` valid
- `mem_req`  out  1  word read request to arbiter
- `mem_addr`  out  32  request address, word aligned
- `mem_ready`  in  1  one-cycle pulse: `mem_data` valid, request complete
- `mem_data`  in  32  returned word

## Operation
- State: fetch pointer `fpc`; output registers (`PC`, `inst_out`, `instcache_ready_out`); cache arrays `valid[LINES]`, `tag[LINES]` (bits 31:IW+2), `data[LINES]`; FSM {IDLE, MISS}; `drop` flag.
- Index is `fpc[IW+1:2]`. Hit requires `valid[idx] && tag[idx]==fpc[31:IW+2]`.
- Consume: at an edge with `instcache_ready_out && need_inst`, the output slot frees.
- Slot free this cycle: output invalid, or being consumed.
- IDLE, slot free, no redirect:
  - Hit: load `PC<=fpc`, `inst_out<=data[idx]`, `ready<=1`, `fpc<=fpc+4` (mod 2^32).
  - Miss: `mem_req<=1`, `mem_addr<=fpc`, go to MISS. If this consumes the slot, `ready<=0`.
- IDLE, slot not free: hold everything.
- MISS: `mem_req`/`mem_addr` stay stable until `mem_ready`.
- On `mem_ready`:
  - Fill `valid/tag/data[idx of mem_addr]`.
  - Drop `mem_req`; go to IDLE.
  - If `drop==0`: load `PC<=mem_addr`, `inst_out<=mem_data`, `ready<=1`, `fpc<=mem_addr+4`.
  - If `drop==1`: clear `drop`, discard the word from the output (the cache is still filled).
- Redirect (`clear_inst` at edge, `rdy` high):
  - `ready<=0`; `fpc<=if_addr & ~32'h3`.
  - If in MISS without `mem_ready`: set `drop<=1` and stay in MISS. The request cannot be cancelled.
  - If `mem_ready` coincides: fill the cache, no output load, go to IDLE.
  - Redirect beats a simultaneous consume or hit.
- There is no cache invalidation other than reset.

## Timing
- Reset (`rst` low, async): `PC=0`, `inst_out=0`, `instcache_ready_out=0`, `mem_req=0`, `mem_addr=0`, all `valid=0`, FSM=IDLE, `drop=0`, `fpc=RESET_PC`.
- Reset asserted mid-miss abandons the request; the arbiter is reset by the same `rst`.
- Hit latency: 1 cycle from slot free to `ready`. Sustained throughput is 1 instruction/cycle while hitting and consumed.
- Miss latency: `mem_req` rises 1 cycle after the lookup. `ready` rises the cycle after `mem_ready`.
- After a redirect, the first new instruction appears no earlier than 1 cycle later (hit), or after any pending miss completes plus the new lookup.
- `rdy` low: no state changes, including `mem_ready` capture. The arbiter must hold `mem_ready` until a `rdy`-high edge.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Test plan
- Cold start, `RESET_PC=0`: `mem_req=1`, `mem_addr=0`. Arbiter returns `0x00000013` after 3 cycles -> `ready=1`, `PC=0`, `inst_out=0x13`; next request is `mem_addr=4`.
- Warm loop: preload lines 0..3, hold `need_inst=1`, redirect to 0 -> PCs 0,4,8,12 on consecutive cycles with no `mem_req`.
- Back-pressure: `need_inst=0` for 4 cycles with `ready=1`, `PC=8` -> `PC`/`inst_out` unchanged and no `fpc` advance; release -> `PC=12` next cycle.
- Redirect during miss: miss at 0x40 pending, `clear_inst=1`, `if_addr=0x103` -> `ready` stays 0. On `mem_ready`, the line for 0x40 is filled with no output. A miss at 0x100 follows; result shows `PC=0x100`.
- Aliasing, `LINES=16`: fetch 0x0 then 0x40 (same index) -> both miss; a refetch of 0x0 misses again.
- `rdy` low for 5 cycles mid-miss with `mem_ready` held -> no change until `rdy` rises; completes the cycle after.
